// File: rtl/key_debounce.sv
// Per-key debouncer: two-flop synchronizer, tick-sampled four-state FSM, registered press/release pulses.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module key_debounce #(
    parameter int NKEY         = 4,
    parameter int STABLE_TICKS = 2,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input  logic            CP,
    input  logic            RST,
    input  logic            tick_20ms,
    input  logic [NKEY-1:0] key_in,
    output logic [NKEY-1:0] key_level,
    output logic [NKEY-1:0] key_press,
    output logic [NKEY-1:0] key_release
);

    localparam int CW = $clog2(STABLE_TICKS);
`ifdef KEY_REPEAT_EN
    localparam int HW = $clog2(HOLD_TICKS + REPEAT_TICKS + 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_e;

    if (STABLE_TICKS < 2 || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("key_debounce: illegal parameter value");
    end

    logic [NKEY-1:0] sync1_q;
    logic [NKEY-1:0] sync2_q;

    always_ff @(posedge CP) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar k = 0; k < NKEY; k++) begin : g_key
        state_e        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          pulse_d;
        logic          sample;
        logic          level;

        assign sample = sync2_q[k];

        always_ff @(posedge CP) begin
            if (RST) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= pulse_d;
                release_q <= release_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (tick_20ms) begin
                unique case (state_q)
                    IDLE: begin
                        if (sample) begin
                            state_d = PRESS_CHK;
                            cnt_d   = CW'(1);
                        end
                    end
                    PRESS_CHK: begin
                        if (!sample) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            press_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!sample) begin
                            state_d = REL_CHK;
                            cnt_d   = CW'(1);
                        end
                    end
                    REL_CHK: begin
                        if (sample) begin
                            state_d = HELD;
                            cnt_d   = '0;
                        end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

`ifdef KEY_REPEAT_EN
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic          rep_d;

        always_ff @(posedge CP) begin
            if (RST) begin
                hcnt_q <= '0;
            end else begin
                hcnt_q <= hcnt_d;
            end
        end

        // Counter restarts on every (re-)entry to HELD; after the first repeat it
        // folds back to HOLD_TICKS so repeats recur every REPEAT_TICKS ticks.
        always_comb begin
            hcnt_d = hcnt_q;
            rep_d  = 1'b0;
            if (state_q != HELD || state_d != HELD) begin
                hcnt_d = '0;
            end else if (tick_20ms) begin
                if (hcnt_q + HW'(1) == HW'(HOLD_TICKS + REPEAT_TICKS)) begin
                    hcnt_d = HW'(HOLD_TICKS);
                    rep_d  = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                    rep_d  = (hcnt_q + HW'(1) == HW'(HOLD_TICKS));
                end
            end
        end

        assign pulse_d = press_d | rep_d;
`else
        assign pulse_d = press_d;
`endif

        always_comb begin
            level = (state_q == HELD) || (state_q == REL_CHK);
        end

        assign key_level[k]   = level;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
    end

endmodule
